// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / load-store data) arbiter for the shared memory bus.
// Define MEM_ARB_RR_EN for round-robin priority; default is fixed data-over-instruction.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              i_ren,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_busy,
   input  logic              d_ren,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_byte_en,
   output logic              d_busy,
   output logic [DATA_W-1:0] rdata,
   output logic              out_ren,
   output logic              out_wen,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_wdata,
   output logic [3:0]        out_byte_en,
   input  logic [DATA_W-1:0] out_rdata,
   input  logic              out_busy,
   output logic              grant_d
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t state;
   logic   cand_i, cand_d, pick_i, pick_d, arb_en;

`ifdef MEM_ARB_RR_EN
   logic   last_served;   // 0 = instruction served last, 1 = data served last
`endif

   // The owner that is completing this cycle is masked so the other side gets the next slot.
   always_comb begin
      cand_d = (d_ren || d_wen) && (state != GNT_D);
      cand_i = i_ren && (state != GNT_I);
      arb_en = (state == IDLE) || !out_busy;
`ifdef MEM_ARB_RR_EN
      pick_d = cand_d && (!cand_i || !last_served);
`else
      pick_d = cand_d;
`endif
      pick_i = cand_i && !pick_d;
   end

   assign i_busy = !((state == GNT_I) && !out_busy);
   assign d_busy = !((state == GNT_D) && !out_busy);
   assign rdata  = out_rdata;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         out_ren     <= 1'b0;
         out_wen     <= 1'b0;
         out_addr    <= '0;
         out_wdata   <= '0;
         out_byte_en <= 4'b0000;
         grant_d     <= 1'b0;
      end else if (arb_en) begin
         if (pick_d) begin
            state       <= GNT_D;
            out_wen     <= d_wen;
            out_ren     <= d_ren && !d_wen;
            out_addr    <= d_addr;
            out_wdata   <= d_wdata;
            out_byte_en <= d_byte_en;
            grant_d     <= 1'b1;
         end else if (pick_i) begin
            state       <= GNT_I;
            out_wen     <= 1'b0;
            out_ren     <= 1'b1;
            out_addr    <= i_addr;
            out_wdata   <= '0;
            out_byte_en <= 4'b1111;
            grant_d     <= 1'b0;
         end else begin
            // Back to IDLE: drop the strobes so the bridge sees no further transaction.
            state   <= IDLE;
            out_ren <= 1'b0;
            out_wen <= 1'b0;
            grant_d <= 1'b0;
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         last_served <= 1'b0;
      else if ((state != IDLE) && !out_busy)
         last_served <= (state == GNT_D);
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Cycle-vector bench for mem_bus_arbiter: table of per-cycle inputs and expected outputs,
// plus hand sequences for asynchronous reset and post-reset priority.
module tb_mem_bus_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        i_ren, d_ren, d_wen, out_busy;
   logic [31:0] i_addr, d_addr, d_wdata, out_rdata;
   logic [3:0]  d_byte_en;
   logic        i_busy, d_busy, out_ren, out_wen, grant_d;
   logic [31:0] rdata, out_addr, out_wdata;
   logic [3:0]  out_byte_en;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .i_ren(i_ren), .i_addr(i_addr), .i_busy(i_busy),
      .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byte_en(d_byte_en), .d_busy(d_busy), .rdata(rdata),
      .out_ren(out_ren), .out_wen(out_wen), .out_addr(out_addr),
      .out_wdata(out_wdata), .out_byte_en(out_byte_en),
      .out_rdata(out_rdata), .out_busy(out_busy), .grant_d(grant_d)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        i_ren;
      logic [31:0] i_addr;
      logic        d_ren, d_wen;
      logic [31:0] d_addr, d_wdata;
      logic [3:0]  d_be;
      logic        ob;
      logic [31:0] ordata;
      logic        e_ren, e_wen;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      logic        e_gd, e_ib, e_db;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                              input logic ob, input logic [31:0] ord,
                              input logic er, input logic ew, input logic [31:0] ea,
                              input logic [31:0] ewd, input logic [3:0] ebe,
                              input logic egd, input logic eib, input logic edb);
      vec_t r;
      r.i_ren = ir; r.i_addr = ia; r.d_ren = dr; r.d_wen = dw; r.d_addr = da;
      r.d_wdata = dwd; r.d_be = dbe; r.ob = ob; r.ordata = ord;
      r.e_ren = er; r.e_wen = ew; r.e_addr = ea; r.e_wdata = ewd; r.e_be = ebe;
      r.e_gd = egd; r.e_ib = eib; r.e_db = edb;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic drive_idle();
      i_ren = 0; i_addr = 0; d_ren = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
      d_byte_en = 0; out_busy = 1; out_rdata = 0;
   endtask

   initial begin
      //      ir ia     dr dw da     dwd          be   ob ord          | er ew ea     ewd          be   gd ib db
      tbl[0]  = v(0, 0,     0, 0, 0,     0,           4'h0, 1, 0,           0, 0, 0,     0,           4'h0, 0, 1, 1);
      tbl[1]  = v(1, 'h100, 1, 0, 'h2000, 0,          4'hF, 1, 0,           0, 0, 0,     0,           4'h0, 0, 1, 1);
      tbl[2]  = v(1, 'h100, 1, 0, 'h2000, 0,          4'hF, 1, 0,           1, 0, 'h2000, 0,          4'hF, 1, 1, 1);
      tbl[3]  = v(1, 'h100, 1, 0, 'h2000, 0,          4'hF, 1, 0,           1, 0, 'h2000, 0,          4'hF, 1, 1, 1);
      tbl[4]  = v(1, 'h100, 1, 0, 'h2000, 0,          4'hF, 0, 'hDEADBEEF,  1, 0, 'h2000, 0,          4'hF, 1, 1, 0);
      tbl[5]  = v(1, 'h100, 0, 0, 0,     0,           4'h0, 0, 'h12345678,  1, 0, 'h100, 0,           4'hF, 0, 0, 1);
      tbl[6]  = v(0, 0,     0, 0, 0,     0,           4'h0, 1, 0,           0, 0, 'h100, 0,           4'hF, 0, 1, 1);
      tbl[7]  = v(0, 0,     0, 1, 'h40,  'hABABABAB,  4'h4, 1, 0,           0, 0, 'h100, 0,           4'hF, 0, 1, 1);
      tbl[8]  = v(0, 0,     0, 1, 'h44,  'h11111111,  4'h1, 1, 0,           0, 1, 'h40,  'hABABABAB,  4'h4, 1, 1, 1);
      tbl[9]  = v(0, 0,     0, 1, 'h44,  'h11111111,  4'h1, 0, 0,           0, 1, 'h40,  'hABABABAB,  4'h4, 1, 1, 0);
      tbl[10] = v(0, 0,     1, 1, 'h80,  'hCDCDCDCD,  4'h3, 1, 0,           0, 0, 'h40,  'hABABABAB,  4'h4, 0, 1, 1);
      tbl[11] = v(0, 0,     1, 1, 'h80,  'hCDCDCDCD,  4'h3, 0, 0,           0, 1, 'h80,  'hCDCDCDCD,  4'h3, 1, 1, 0);
      tbl[12] = v(0, 0,     0, 0, 0,     0,           4'h0, 1, 0,           0, 0, 'h80,  'hCDCDCDCD,  4'h3, 0, 1, 1);
      tbl[13] = v(1, 'h200, 0, 0, 0,     0,           4'h0, 1, 0,           0, 0, 'h80,  'hCDCDCDCD,  4'h3, 0, 1, 1);
      tbl[14] = v(0, 0,     0, 0, 0,     0,           4'h0, 1, 0,           1, 0, 'h200, 0,           4'hF, 0, 1, 1);
      tbl[15] = v(0, 0,     0, 0, 0,     0,           4'h0, 1, 0,           1, 0, 'h200, 0,           4'hF, 0, 1, 1);
      tbl[16] = v(0, 0,     0, 0, 0,     0,           4'h0, 1, 0,           1, 0, 'h200, 0,           4'hF, 0, 1, 1);
      tbl[17] = v(0, 0,     0, 0, 0,     0,           4'h0, 0, 0,           1, 0, 'h200, 0,           4'hF, 0, 0, 1);
      tbl[18] = v(0, 0,     0, 0, 0,     0,           4'h0, 1, 0,           0, 0, 'h200, 0,           4'hF, 0, 1, 1);
      tbl[19] = v(0, 0,     0, 0, 0,     0,           4'h0, 0, 0,           0, 0, 'h200, 0,           4'hF, 0, 1, 1);
      tbl[20] = v(1, 'h300, 1, 0, 'h400, 0,           4'hF, 1, 0,           0, 0, 'h200, 0,           4'hF, 0, 1, 1);
      tbl[21] = v(1, 'h300, 1, 0, 'h400, 0,           4'hF, 0, 0,           1, 0, 'h400, 0,           4'hF, 1, 1, 0);
      tbl[22] = v(1, 'h300, 1, 0, 'h400, 0,           4'hF, 1, 0,           1, 0, 'h300, 0,           4'hF, 0, 1, 1);
      tbl[23] = v(1, 'h300, 1, 0, 'h400, 0,           4'hF, 0, 0,           1, 0, 'h300, 0,           4'hF, 0, 0, 1);
      tbl[24] = v(1, 'h300, 1, 0, 'h400, 0,           4'hF, 1, 0,           1, 0, 'h400, 0,           4'hF, 1, 1, 1);
      tbl[25] = v(1, 'h300, 1, 0, 'h400, 0,           4'hF, 0, 0,           1, 0, 'h400, 0,           4'hF, 1, 1, 0);
      tbl[26] = v(1, 'h300, 1, 0, 'h400, 0,           4'hF, 1, 0,           1, 0, 'h300, 0,           4'hF, 0, 1, 1);

      // Reset state, with requests present to show they are ignored under reset.
      drive_idle();
      nRST = 1'b0;
      i_ren = 1; d_wen = 1; d_addr = 'h55;
      repeat (2) @(negedge CLK);
      chk("rst_out_ren", {31'b0, out_ren}, 0);
      chk("rst_out_wen", {31'b0, out_wen}, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_be", {28'b0, out_byte_en}, 0);
      chk("rst_grant_d", {31'b0, grant_d}, 0);
      chk("rst_i_busy", {31'b0, i_busy}, 1);
      chk("rst_d_busy", {31'b0, d_busy}, 1);
      drive_idle();
      nRST = 1'b1;

      for (int k = 0; k < 27; k++) begin
         @(negedge CLK);
         i_ren = tbl[k].i_ren; i_addr = tbl[k].i_addr;
         d_ren = tbl[k].d_ren; d_wen = tbl[k].d_wen; d_addr = tbl[k].d_addr;
         d_wdata = tbl[k].d_wdata; d_byte_en = tbl[k].d_be;
         out_busy = tbl[k].ob; out_rdata = tbl[k].ordata;
         #2;
         chk($sformatf("v%0d_out_ren", k), {31'b0, out_ren}, {31'b0, tbl[k].e_ren});
         chk($sformatf("v%0d_out_wen", k), {31'b0, out_wen}, {31'b0, tbl[k].e_wen});
         chk($sformatf("v%0d_out_addr", k), out_addr, tbl[k].e_addr);
         chk($sformatf("v%0d_out_wdata", k), out_wdata, tbl[k].e_wdata);
         chk($sformatf("v%0d_out_be", k), {28'b0, out_byte_en}, {28'b0, tbl[k].e_be});
         chk($sformatf("v%0d_grant_d", k), {31'b0, grant_d}, {31'b0, tbl[k].e_gd});
         chk($sformatf("v%0d_i_busy", k), {31'b0, i_busy}, {31'b0, tbl[k].e_ib});
         chk($sformatf("v%0d_d_busy", k), {31'b0, d_busy}, {31'b0, tbl[k].e_db});
         chk($sformatf("v%0d_rdata", k), rdata, tbl[k].ordata);
      end

      // Fresh reset with both requesting: data is served first.
      @(negedge CLK);
      drive_idle();
      nRST = 1'b0;
      #1 nRST = 1'b1;
      i_ren = 1; i_addr = 'h700; d_ren = 1; d_addr = 'h800; d_byte_en = 4'hF;
      @(negedge CLK);
      #2;
      chk("prio_grant_d", {31'b0, grant_d}, 1);
      chk("prio_out_addr", out_addr, 'h800);

      // Asynchronous reset in the middle of a data write.
      @(negedge CLK);
      drive_idle();
      nRST = 1'b0;
      #1 nRST = 1'b1;
      d_wen = 1; d_addr = 'h900; d_wdata = 'h5A5A5A5A; d_byte_en = 4'h8;
      @(negedge CLK);
      #1;
      chk("mid_pre_wen", {31'b0, out_wen}, 1);
      chk("mid_pre_gd", {31'b0, grant_d}, 1);
      nRST = 1'b0;
      #1;
      chk("mid_rst_wen", {31'b0, out_wen}, 0);
      chk("mid_rst_gd", {31'b0, grant_d}, 0);
      chk("mid_rst_d_busy", {31'b0, d_busy}, 1);
      chk("mid_rst_i_busy", {31'b0, i_busy}, 1);
      chk("mid_rst_addr", out_addr, 0);
      drive_idle();
      #1 nRST = 1'b1;
      out_busy = 1'b0;
      @(negedge CLK);
      #2;
      chk("post_rst_wen", {31'b0, out_wen}, 0);
      chk("post_rst_ren", {31'b0, out_ren}, 0);
      chk("post_rst_d_busy", {31'b0, d_busy}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch requester and the load/store unit's data requester.
- Sits between the fetch stage / load-store unit and the bus-bridge port. It latches the winning request and holds it stable downstream until the bus completes.
- Returns a per-requester busy, so the hazard unit's d_mem_busy / i_mem_busy track only the owner's transaction.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
i_ren  input  1  instruction read request, held until i_busy low
i_addr  input  ADDR_W  instruction address
i_busy  output  1  low for exactly the completion cycle of an instruction transaction
d_ren  input  1  data read request
d_wen  input  1  data write request
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data, already lane-replicated
d_byte_en  input  4  data byte enables
d_busy  output  1  low for exactly the completion cycle of a data transaction
rdata  output  DATA_W  combinational pass-through of out_rdata to both requesters
out_ren  output  1  downstream read strobe
out_wen  output  1  downstream write strobe
out_addr  output  ADDR_W  downstream address
out_wdata  output  DATA_W  downstream write data
out_byte_en  output  4  downstream byte enables
out_rdata  input  DATA_W  downstream read data
out_busy  input  1  downstream busy; low = current transaction completes this cycle
grant_d  output  1  1 while the data requester owns the bus (hazard visibility)

Behaviour:
- Reset (nRST low, async; legal mid-transaction):
  - State goes to IDLE and any latched transaction is dropped.
  - out_ren, out_wen, out_addr, out_wdata, out_byte_en and grant_d all go to 0.
  - i_busy and d_busy go to 1.
- State machine: IDLE, GNT_I, GNT_D.
- IDLE:
  - Data wins over instruction if both request (fixed priority).
  - On a chosen requester, latch its addr/wdata/byte_en/strobes into out_* registers and move to GNT_D or GNT_I at the next edge.
  - Grant latency is therefore one cycle: out_* are valid the cycle after the request is first seen in IDLE.
- GNT_x:
  - out_* are held constant irrespective of requester inputs.
  - When out_busy==0, the transaction completes: x_busy=0 combinationally in that same cycle, and rdata carries valid read data.
- Completion-cycle arbitration:
  - The completing requester is masked out.
  - If the other requester is requesting, latch it and go straight to its GNT state (no IDLE bubble). Otherwise return to IDLE.
- d_ren and d_wen both high: treated as a write. out_wen=1, out_ren=0.
- Instruction grants always drive out_wen=0, out_wdata=0 and out_byte_en=4'b1111.
- Requester drops its request while granted (flush): the downstream transaction still runs to completion. The completion is consumed silently, and a new request is not accepted until that completion.
- Non-owner busy is held at 1. Both busy outputs are 1 in IDLE.
- out_busy is ignored in IDLE.
- grant_d = (state==GNT_D).

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last_served register (reset 0 = instruction) gives priority to the requester not served last.
  - It updates at every completion.
  - The completion-cycle masking rule still applies.
- Undefined: fixed data-over-instruction priority; no last_served register.

Test Plan:
- Reset mid-transaction:
  - Stimulus: in GNT_D with out_wen=1, pulse nRST low.
  - Response: out_wen=0, d_busy=1, i_busy=1 and grant_d=0 immediately (asynchronous); state IDLE after release.
- Simultaneous request, fixed priority:
  - Stimulus: i_ren=1 at i_addr=0x100 and d_ren=1 at d_addr=0x2000, same cycle; out_busy=1 for 2 cycles, then 0.
  - Response: next cycle out_addr=0x2000, out_ren=1, grant_d=1; d_busy=0 in the completion cycle.
  - Response: the following cycle out_addr=0x100, out_ren=1, with no IDLE cycle between.
- Write path:
  - Stimulus: d_wen=1, d_addr=0x40, d_wdata=0xABABABAB, d_byte_en=4'b0100.
  - Response: out_wen=1, out_ren=0, out_wdata=0xABABABAB, out_byte_en=4'b0100, all held stable until out_busy=0.
  - Repeat with d_ren=d_wen=1 -> out_ren=0, out_wen=1.
- Flush while granted:
  - Stimulus: grant I at 0x200, deassert i_ren the next cycle, out_busy=1 for 3 cycles.
  - Response: out_ren and out_addr=0x200 stay held; state returns to IDLE after out_busy=0; no second transaction issued.
- Starvation / round-robin:
  - Stimulus: hold d_ren and i_ren high continuously, out_busy toggling 1,0 every cycle.
  - Response without MEM_ARB_RR_EN: D and I alternate, because the completing requester is masked.
  - Response with MEM_ARB_RR_EN: D and I also alternate; in addition, after reset with both requesting, D is served first (last_served=0 gives D priority).
- rdata pass-through:
  - Stimulus: read completes with out_rdata=0xDEADBEEF.
  - Response: rdata=0xDEADBEEF and the owner's busy=0 in that same cycle.
